lcd_responder: RTL

//  HD44780-compatible responder: the display-side end of the lcd_rs/lcd_rw/lcd_en/lcd_data bus.

---
 rtl/lcd_responder_pkg.sv | 21 ++
 rtl/lcd_responder_if.sv | 19 +
 rtl/lcd_responder_addr_map.sv | 17 +
 rtl/lcd_responder.sv | 167 ++++++++++++++++
 4 files changed

// File: rtl/lcd_responder_pkg.sv
// rtl/lcd_responder_pkg.sv - shared constants, timing defaults and state encoding for the LCD responder
package lcd_pkg;

   localparam int unsigned CHAR_CYC_DEF   = 2500;
   localparam int unsigned CLEAR_CYC_DEF  = 100000;
   localparam int unsigned EN_MIN_CYC_DEF = 10;

   localparam logic [7:0] CMD_CLEAR  = 8'h01;
   localparam logic [7:0] CMD_HOME   = 8'h02;
   localparam logic [7:0] CMD_SETDD  = 8'h80;
   localparam logic [6:0] LINE2_BASE = 7'h40;
   localparam logic [7:0] BLANK_CHAR = 8'h20;
   localparam int         BUF_DEPTH  = 32;

   typedef enum logic [1:0] {
      S_IDLE  = 2'd0,
      S_CLEAR = 2'd1,
      S_BUSY  = 2'd2
   } state_e;

endpackage

// File: rtl/lcd_responder_if.sv
// rtl/lcd_responder_if.sv - HD44780-style parallel bus between the LCD driver and the display side
interface lcd_responder_if;
   logic       lcd_rs;
   logic       lcd_rw;
   logic       lcd_en;
   logic [7:0] lcd_data_in;
   logic [7:0] lcd_data_out;
   logic       lcd_data_oe;

   modport master (
      output lcd_rs, lcd_rw, lcd_en, lcd_data_in,
      input  lcd_data_out, lcd_data_oe
   );

   modport slave (
      input  lcd_rs, lcd_rw, lcd_en, lcd_data_in,
      output lcd_data_out, lcd_data_oe
   );
endinterface

// File: rtl/lcd_responder_addr_map.sv
// rtl/lcd_responder_addr_map.sv - DDRAM address counter to buffer index map and AC increment wrap
module lcd_addr_map
   import lcd_pkg::*;
(
   input  logic [6:0] ac_i,
   output logic       visible_o,
   output logic [4:0] idx_o,
   output logic [6:0] ac_next_o
);
   // Only the first 16 columns of each 40-column line are mirrored.
   assign visible_o = (ac_i[6:4] == 3'b000) || (ac_i[6:4] == LINE2_BASE[6:4]);
   assign idx_o     = {ac_i[6], ac_i[3:0]};

   assign ac_next_o = (ac_i == 7'h27)               ? LINE2_BASE :
                      (ac_i == LINE2_BASE + 7'h27)  ? 7'h00      :
                                                      ac_i + 7'd1;
endmodule

// File: rtl/lcd_responder.sv
// rtl/lcd_responder.sv - display-side HD44780 responder: decodes bus transactions into a 2x16 mirror
module lcd_responder
   import lcd_pkg::*;
#(
   parameter int unsigned CHAR_CYC   = CHAR_CYC_DEF,
   parameter int unsigned CLEAR_CYC  = CLEAR_CYC_DEF,
   parameter int unsigned EN_MIN_CYC = EN_MIN_CYC_DEF
) (
   input  logic           clk,
   input  logic           rst_n,
   lcd_responder_if.slave lcd,
   output logic           busy,
   output logic [6:0]     ddram_addr,
   input  logic [4:0]     rd_addr,
   output logic [7:0]     rd_char,
   output logic           clear_evt,
   output logic           overrun
);
   localparam int CNT_W = $clog2(CLEAR_CYC + 1);
   localparam int EN_W  = $clog2(EN_MIN_CYC + 1);
   localparam logic [CNT_W-1:0] CHAR_LOAD  = CNT_W'(CHAR_CYC - 1);
   localparam logic [CNT_W-1:0] CLEAR_LOAD = CNT_W'(CLEAR_CYC - BUF_DEPTH - 1);
   localparam logic [EN_W-1:0]  EN_SAT     = EN_W'(EN_MIN_CYC);

   state_e           state_q, state_d;
   logic [CNT_W-1:0] cnt_q, cnt_d;
   logic [4:0]       fill_q, fill_d;
   logic [6:0]       ac_q, ac_d;
   logic             clear_evt_q, clear_evt_d;
   logic             overrun_q, overrun_d;
   logic             en_prev_q;
   logic [EN_W-1:0]  en_cnt_q;
   logic             rs_q, rw_q;
   logic [7:0]       data_q;
   logic [7:0]       buf_q [BUF_DEPTH];
   logic [7:0]       rd_char_q;

   logic             buf_we;
   logic [4:0]       buf_widx;
   logic [7:0]       buf_wdata;
   logic             ac_vis;
   logic [4:0]       ac_idx;
   logic [6:0]       ac_next;
   logic             fall, accept, rd_oe;

   lcd_addr_map u_addr_map (
      .ac_i      (ac_q),
      .visible_o (ac_vis),
      .idx_o     (ac_idx),
      .ac_next_o (ac_next)
   );

   assign fall   = en_prev_q & ~lcd.lcd_en;
   assign accept = fall & (en_cnt_q >= EN_SAT);

   always_comb begin
      state_d     = state_q;
      cnt_d       = cnt_q;
      fill_d      = fill_q;
      ac_d        = ac_q;
      clear_evt_d = 1'b0;
      overrun_d   = overrun_q;
      buf_we      = 1'b0;
      buf_widx    = ac_idx;
      buf_wdata   = data_q;

      case (state_q)
         S_CLEAR: begin
            buf_we    = 1'b1;
            buf_widx  = fill_q;
            buf_wdata = BLANK_CHAR;
            fill_d    = fill_q + 5'd1;
            ac_d      = '0;
            if (fill_q == 5'd31) begin
               state_d     = S_BUSY;
               cnt_d       = CLEAR_LOAD;
               clear_evt_d = 1'b1;
            end
         end
         S_BUSY: begin
            if (cnt_q == '0) state_d = S_IDLE;
            else             cnt_d   = cnt_q - 1'b1;
         end
         default: ;
      endcase

      if (fall && !accept) overrun_d = 1'b1;

      // rs/rw/data were registered on the last high cycle, so they describe this transaction.
      if (accept) begin
         if (state_q != S_IDLE) overrun_d = 1'b1;
         if (state_q != S_CLEAR) begin
            if (!rw_q) begin
               state_d = S_BUSY;
               cnt_d   = CHAR_LOAD;
               if (rs_q) begin
                  buf_we = ac_vis;
                  ac_d   = ac_next;
               end else if ((data_q & CMD_SETDD) != 8'h00) begin
                  ac_d = data_q[6:0];
               end else if (data_q == CMD_CLEAR) begin
                  state_d = S_CLEAR;
                  fill_d  = '0;
                  ac_d    = '0;
               end else if (data_q[7:1] == CMD_HOME[7:1]) begin
                  ac_d = '0;
               end
            end else if (rs_q) begin
               ac_d    = ac_next;
               state_d = S_BUSY;
               cnt_d   = CHAR_LOAD;
            end
         end
      end
   end

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         state_q     <= S_IDLE;
         cnt_q       <= '0;
         fill_q      <= '0;
         ac_q        <= '0;
         clear_evt_q <= 1'b0;
         overrun_q   <= 1'b0;
         en_prev_q   <= 1'b0;
         en_cnt_q    <= '0;
         rs_q        <= 1'b0;
         rw_q        <= 1'b0;
         data_q      <= '0;
      end else begin
         state_q     <= state_d;
         cnt_q       <= cnt_d;
         fill_q      <= fill_d;
         ac_q        <= ac_d;
         clear_evt_q <= clear_evt_d;
         overrun_q   <= overrun_d;
         en_prev_q   <= lcd.lcd_en;
         rs_q        <= lcd.lcd_rs;
         rw_q        <= lcd.lcd_rw;
         data_q      <= lcd.lcd_data_in;
         if (!lcd.lcd_en)           en_cnt_q <= '0;
         else if (en_cnt_q != EN_SAT) en_cnt_q <= en_cnt_q + 1'b1;
      end
   end

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         for (int i = 0; i < BUF_DEPTH; i++) buf_q[i] <= BLANK_CHAR;
         rd_char_q <= BLANK_CHAR;
      end else begin
         rd_char_q <= buf_q[rd_addr];
         if (buf_we) buf_q[buf_widx] <= buf_wdata;
      end
   end

   assign rd_oe            = lcd.lcd_en & lcd.lcd_rw;
   assign lcd.lcd_data_oe  = rd_oe;
   assign lcd.lcd_data_out = !rd_oe      ? 8'h00 :
                             lcd.lcd_rs  ? (ac_vis ? buf_q[ac_idx] : BLANK_CHAR) :
                                           {busy, ac_q};

   assign busy       = (state_q != S_IDLE);
   assign ddram_addr = ac_q;
   assign rd_char    = rd_char_q;
   assign clear_evt  = clear_evt_q;
   assign overrun    = overrun_q;
endmodule
